// File: rtl/ex_pkg.sv
// ex_pkg: shared EX-stage constants, funct3 divide codes and divider state enum
package ex_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE} div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration; in rem/quo/divisor, out next rem/quo
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);
  logic [XLEN:0] trial;
  always_comb begin
    trial   = {rem, quo[XLEN-1]} - {1'b0, divisor};
    rem_nxt = trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : trial[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], ~trial[XLEN]};
  end
endmodule

// File: rtl/ex_div_seq.sv
// ex_div_seq: multi-cycle DIV/DIVU/REM/REMU sequencer; start/funct3/op_a/op_b/flush in, stall/busy/done/result out
module ex_div_seq
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  div_state_e state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sel_rem_q, sel_rem_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic accept, sgn;
  div_step #(.XLEN(XLEN)) u_step (
    .rem(rem_q), .quo(quo_q), .divisor(dvs_q), .rem_nxt(step_rem), .quo_nxt(step_quo)
  );
  always_comb begin
    accept    = (state_q == DIV_IDLE) & start & funct3[2] & ~flush;
    sgn       = ~funct3[0];
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    sel_rem_d = sel_rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    case (state_q)
      DIV_IDLE: if (accept) begin
        sel_rem_d = funct3[1];
        qneg_d    = sgn & (op_a[XLEN-1] ^ op_b[XLEN-1]);
        rneg_d    = sgn & op_a[XLEN-1];
        rem_d     = '0;
        quo_d     = (sgn & op_a[XLEN-1]) ? -op_a : op_a;
        dvs_d     = (sgn & op_b[XLEN-1]) ? -op_b : op_b;
        cnt_d     = '0;
        state_d   = DIV_CALC;
        if (op_b == '0) begin
          result_d = funct3[1] ? op_a : '1;
          state_d  = DIV_DONE;
        end else if (sgn && op_a == MIN && op_b == '1) begin
          result_d = funct3[1] ? '0 : MIN;
          state_d  = DIV_DONE;
        end
      end
      DIV_CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        cnt_d   = cnt_q + CW'(1);
        state_d = flush ? DIV_IDLE : (cnt_q == LAST ? DIV_FIX : DIV_CALC);
      end
      DIV_FIX: begin
        result_d = flush ? result_q : sel_rem_q ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);
        state_d  = flush ? DIV_IDLE : DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      sel_rem_q <= sel_rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
    end
  end
  assign stall  = accept | (state_q == DIV_CALC) | (state_q == DIV_FIX);
  assign busy   = state_q != DIV_IDLE;
  assign done   = state_q == DIV_DONE;
  assign result = result_q;
endmodule

// File: tb/tb_ex_div_seq.sv
// tb_ex_div_seq: scoreboard bench for ex_div_seq
module tb_ex_div_seq;
  import ex_pkg::*;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic clk = 0, rst_n = 0, start = 0, flush = 0;
  logic [2:0] funct3 = 3'b000;
  logic [31:0] op_a = 0, op_b = 0;
  logic stall, busy, done;
  logic [31:0] result;
  int cyc = 0, checks = 0, errors = 0;
  logic [31:0] last_exp = 0;
  typedef struct {logic [31:0] res; int due;} exp_t;
  exp_t sb[$];
  ex_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == MIN && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : MIN;
    if (f[0]) return f[1] ? a % b : a / b;
    return f[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) check("spurious_done", {31'b0, done}, 32'd0);
      else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("done_cycle", cyc, e.due);
      end
    end
  end
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit glitch);
    int lat;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1;
    #1 check("stall_accept", {31'b0, stall}, 32'd1);
    lat = (b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF)) ? 1 : 34;
    last_exp = model(f, a, b);
    sb.push_back('{last_exp, cyc + lat});
    @(negedge clk);
    start = 0; op_a = $urandom; op_b = $urandom;
    for (int k = 1; k <= lat; k++) begin
      start = glitch && k == 5;
      if (start) funct3 = F3_DIV;
      #1 check("stall", {31'b0, stall}, {31'b0, k < lat});
      check("busy", {31'b0, busy}, 32'd1);
      if (k == lat) break;
      @(negedge clk);
    end
  endtask
  initial begin
    logic [2:0] f;
    repeat (2) @(negedge clk);
    #1 check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1;
    run_op(F3_DIVU, 100, 7, 0);
    run_op(F3_REMU, 100, 7, 0);
    run_op(F3_DIV, -32'sd7, 2, 0);
    run_op(F3_REM, -32'sd7, 2, 0);
    run_op(F3_DIV, 32'h1234, 0, 0);
    run_op(F3_REM, 32'h1234, 0, 0);
    run_op(F3_DIV, MIN, 32'hFFFF_FFFF, 0);
    run_op(F3_REM, MIN, 32'hFFFF_FFFF, 0);
    run_op(F3_DIVU, MIN, 32'hFFFF_FFFF, 0);
    run_op(F3_DIV, 1000, -32'sd7, 1);
    for (int i = 0; i < 6; i++) begin
      f = {1'b1, 2'($urandom_range(0, 3))};
      run_op(f, $urandom, $urandom_range(1, 32'h0001_0000) << $urandom_range(0, 12), 0);
    end
    @(negedge clk);
    funct3 = 3'b001; op_a = 50; op_b = 5; start = 1;
    #1 check("nondiv_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    start = 0;
    #1 check("nondiv_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    funct3 = F3_DIVU; op_a = 1000; op_b = 3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1 check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result", result, last_exp);
    run_op(F3_DIVU, 9, 3, 0);
    @(negedge clk);
    funct3 = F3_DIVU; op_a = 77; op_b = 5; start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    rst_n = 0;
    #1 check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_stall", {31'b0, stall}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1;
    run_op(F3_DIVU, 32'hFFFF_FFFF, 1, 0);
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
